// File: rtl/mem_bus_arb_if.sv
// Memory-side bus bundle shared by the arbiter (dev) and the memory slave (host).
// sel_i and we_i are active-low; clk_i is the single clock for everything on the bus.
interface mem_wif_t #(
    parameter int AW = 32,
    parameter int DW = 16
) (
    input logic clk_i
);
    logic          sel_i;
    logic          we_i;
    logic          stb_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] dat_o;
    logic          ack_o;
    logic          cyc_o;
    logic          stb_o;
    logic [DW-1:0] dat_i;

    modport dev (
        input  clk_i, ack_o, cyc_o, stb_o, dat_i,
        output sel_i, addr_i, dat_o, we_i, stb_i
    );

    modport host (
        input  clk_i, sel_i, addr_i, dat_o, we_i, stb_i,
        output ack_o, cyc_o, stb_o, dat_i
    );
endinterface

// File: rtl/mem_bus_arb.sv
// Arbiter giving NREQ request/ack masters turns on one mem_wif_t port.
// Define MEM_BUS_ARB_RR_EN for round-robin selection; otherwise lowest index wins.
//
// state   | meaning
// IDLE    | no transaction; sample pending requests, latch winner
// GRANT   | request the bus (sel_i low) until ack_o=1 with cyc_o=0, then strobe
// STROBE  | stb_i high, wait for stb_o; writes complete here
// RD_TAIL | read: wait for cyc_o=0, capture dat_i and ack the master
// DONE    | one idle cycle so the served master can drop its request
module mem_bus_arb #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 16
) (
    input  logic                     rst_i,
    mem_wif_t.dev                    mem,
    input  logic [NREQ-1:0]          req_rd_i,
    input  logic [NREQ-1:0]          req_wr_i,
    input  logic [NREQ-1:0][AW-1:0]  req_addr_i,
    input  logic [NREQ-1:0][DW-1:0]  req_dat_i,
    output logic [DW-1:0]            rsp_dat_o,
    output logic [NREQ-1:0]          rsp_ack_o,
    output logic [NREQ-1:0]          gnt_o,
    output logic                     busy_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = IW + 1;

    typedef enum logic [2:0] {IDLE, GRANT, STROBE, RD_TAIL, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   win_q, win_d, win;
    logic            found;
    logic            rd_q, rd_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdat_q, wdat_d;
    logic            sel_q, sel_d;
    logic            we_q, we_d;
    logic            stb_q, stb_d;
    logic [AW-1:0]   aout_q, aout_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic [DW-1:0]   rdat_q, rdat_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] pending;

    assign pending = req_rd_i | req_wr_i;

`ifdef MEM_BUS_ARB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;

    always_comb begin
        logic [CW-1:0] cand;
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = CW'(ptr_q) + CW'(i);
            if (cand >= CW'(NREQ))
                cand = cand - CW'(NREQ);
            if (!found && pending[cand[IW-1:0]]) begin
                found = 1'b1;
                win   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == DONE)
            ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
    end

    always_ff @(posedge mem.clk_i) begin
        if (rst_i)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && pending[i]) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        stb_d   = stb_q;
        aout_d  = aout_q;
        dout_d  = dout_q;
        rdat_d  = rdat_q;
        ack_d   = '0;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = win;
                    rd_d    = req_rd_i[win];
                    addr_d  = req_addr_i[win];
                    wdat_d  = req_dat_i[win];
                    gnt_d   = NREQ'(1) << win;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!mem.cyc_o) begin
                    if (!mem.ack_o) begin
                        sel_d = 1'b0;
                    end else begin
                        sel_d  = 1'b1;
                        aout_d = addr_q;
                        stb_d  = 1'b1;
                        if (!rd_q) begin
                            we_d   = 1'b0;
                            dout_d = wdat_q;
                        end
                        state_d = STROBE;
                    end
                end
            end
            STROBE: begin
                if (mem.stb_o) begin
                    stb_d  = 1'b0;
                    we_d   = 1'b1;
                    dout_d = '0;
                    if (rd_q) begin
                        state_d = RD_TAIL;
                    end else begin
                        ack_d   = gnt_q;
                        aout_d  = '0;
                        state_d = DONE;
                    end
                end
            end
            RD_TAIL: begin
                if (!mem.cyc_o) begin
                    rdat_d  = mem.dat_i;
                    aout_d  = '0;
                    ack_d   = gnt_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mem.clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            win_q   <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdat_q  <= '0;
            sel_q   <= 1'b1;
            we_q    <= 1'b1;
            stb_q   <= 1'b0;
            aout_q  <= '0;
            dout_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            aout_q  <= aout_d;
            dout_q  <= dout_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            gnt_q   <= gnt_d;
        end
    end

    assign mem.sel_i  = sel_q;
    assign mem.we_i   = we_q;
    assign mem.stb_i  = stb_q;
    assign mem.addr_i = aout_q;
    assign mem.dat_o  = dout_q;
    assign rsp_dat_o  = rdat_q;
    assign rsp_ack_o  = ack_q;
    assign gnt_o      = gnt_q;
    assign busy_o     = (state_q != IDLE);
endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb with a two-port configuration and a scripted memory slave.
module tb_mem_bus_arb;
    localparam int NREQ = 2;
    localparam int AW   = 32;
    localparam int DW   = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_rd, req_wr;
    logic [NREQ-1:0][AW-1:0] req_addr;
    logic [NREQ-1:0][DW-1:0] req_dat;
    logic [DW-1:0]           rsp_dat;
    logic [NREQ-1:0]         rsp_ack, gnt;
    logic                    busy;

    logic          m_ack, m_cyc, m_stb_en;
    logic [DW-1:0] m_rdata;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    mem_wif_t #(.AW(AW), .DW(DW)) mem (.clk_i(clk));

    // Slave echoes the strobe back while enabled, so stb_o follows stb_i.
    assign mem.ack_o = m_ack;
    assign mem.cyc_o = m_cyc;
    assign mem.stb_o = mem.stb_i & m_stb_en;
    assign mem.dat_i = m_rdata;

    mem_bus_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .rst_i      (rst),
        .mem        (mem),
        .req_rd_i   (req_rd),
        .req_wr_i   (req_wr),
        .req_addr_i (req_addr),
        .req_dat_i  (req_dat),
        .rsp_dat_o  (rsp_dat),
        .rsp_ack_o  (rsp_ack),
        .gnt_o      (gnt),
        .busy_o     (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic sel, input logic stb, input logic we,
                           input logic [31:0] addr, input logic [15:0] dat);
        chk({tag, ".sel"},  32'(mem.sel_i),  32'(sel));
        chk({tag, ".stb"},  32'(mem.stb_i),  32'(stb));
        chk({tag, ".we"},   32'(mem.we_i),   32'(we));
        chk({tag, ".addr"}, mem.addr_i,      addr);
        chk({tag, ".dat"},  32'(mem.dat_o),  32'(dat));
    endtask

    logic [1:0] exp_gnt;

    initial begin
        rst      = 1'b1;
        req_rd   = '0;
        req_wr   = '0;
        req_addr = '0;
        req_dat  = '0;
        m_ack    = 1'b1;
        m_cyc    = 1'b0;
        m_stb_en = 1'b1;
        m_rdata  = '0;
        tick();
        tick();

        // reset state
        chk_bus("rst", 1'b1, 1'b0, 1'b1, 32'h0, 16'h0);
        chk("rst.ack",  32'(rsp_ack), 32'h0);
        chk("rst.rdat", 32'(rsp_dat), 32'h0);
        chk("rst.gnt",  32'(gnt),     32'h0);
        chk("rst.busy", 32'(busy),    32'h0);

        // single read, port 0
        rst         = 1'b0;
        req_rd[0]   = 1'b1;
        req_addr[0] = 32'h0000_0010;
        m_rdata     = 16'hBEEF;
        tick();
        chk("rd.E.gnt",  32'(gnt),  32'h1);
        chk("rd.E.busy", 32'(busy), 32'h1);
        chk_bus("rd.E", 1'b1, 1'b0, 1'b1, 32'h0, 16'h0);
        tick();
        chk_bus("rd.E1", 1'b1, 1'b1, 1'b1, 32'h10, 16'h0);
        chk("rd.E1.ack", 32'(rsp_ack), 32'h0);
        tick();
        chk("rd.E2.stb", 32'(mem.stb_i), 32'h0);
        chk("rd.E2.ack", 32'(rsp_ack),   32'h0);
        tick();
        chk("rd.E3.ack",  32'(rsp_ack), 32'h1);
        chk("rd.E3.rdat", 32'(rsp_dat), 32'hBEEF);
        chk("rd.E3.addr", mem.addr_i,   32'h0);
        chk("rd.E3.gnt",  32'(gnt),     32'h1);
        req_rd[0] = 1'b0;
        m_rdata   = 16'h0000;
        tick();
        chk("rd.E4.ack",  32'(rsp_ack), 32'h0);
        chk("rd.E4.gnt",  32'(gnt),     32'h0);
        chk("rd.E4.busy", 32'(busy),    32'h0);
        chk("rd.E4.rdat", 32'(rsp_dat), 32'hBEEF);

        // single write, port 1
        req_wr[1]   = 1'b1;
        req_addr[1] = 32'h20;
        req_dat[1]  = 16'h1234;
        tick();
        chk("wr.E.gnt", 32'(gnt), 32'h2);
        tick();
        chk_bus("wr.E1", 1'b1, 1'b1, 1'b0, 32'h20, 16'h1234);
        tick();
        chk("wr.E2.ack", 32'(rsp_ack), 32'h2);
        chk_bus("wr.E2", 1'b1, 1'b0, 1'b1, 32'h0, 16'h0);
        req_wr[1] = 1'b0;
        tick();
        chk("wr.E3.ack",  32'(rsp_ack), 32'h0);
        chk("wr.E3.gnt",  32'(gnt),     32'h0);
        chk("wr.E3.rdat", 32'(rsp_dat), 32'hBEEF);

        // ports 0 and 1 reading continuously
        req_rd      = 2'b11;
        req_addr[0] = 32'h100;
        req_addr[1] = 32'h104;
        m_rdata     = 16'h0A0A;
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_BUS_ARB_RR_EN
            exp_gnt = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_gnt = 2'b01;
`endif
            tick();
            chk($sformatf("pair%0d.gnt", t), 32'(gnt), 32'(exp_gnt));
            tick();
            chk($sformatf("pair%0d.addr", t), mem.addr_i, (exp_gnt == 2'b01) ? 32'h100 : 32'h104);
            tick();
            tick();
            chk($sformatf("pair%0d.ack", t), 32'(rsp_ack), 32'(exp_gnt));
            tick();
        end
        req_rd = '0;
        tick();
        chk("pair.idle", 32'(busy), 32'h0);

        // memory withholds ack_o for five cycles, then a cyc_o stall in RD_TAIL
        m_ack       = 1'b0;
        req_rd[0]   = 1'b1;
        req_addr[0] = 32'h40;
        m_rdata     = 16'h5A5A;
        tick();
        chk("st.E.gnt", 32'(gnt),       32'h1);
        chk("st.E.sel", 32'(mem.sel_i), 32'h1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("st.w%0d.sel", c), 32'(mem.sel_i), 32'h0);
            chk($sformatf("st.w%0d.stb", c), 32'(mem.stb_i), 32'h0);
            chk($sformatf("st.w%0d.ack", c), 32'(rsp_ack),   32'h0);
        end
        m_ack = 1'b1;
        tick();
        chk_bus("st.go", 1'b1, 1'b1, 1'b1, 32'h40, 16'h0);
        m_cyc = 1'b1;
        tick();
        chk("st.strobe.stb", 32'(mem.stb_i), 32'h0);
        tick();
        chk("st.tail.ack", 32'(rsp_ack), 32'h0);
        chk("st.tail.busy", 32'(busy),   32'h1);
        m_cyc = 1'b0;
        tick();
        chk("st.ack",  32'(rsp_ack), 32'h1);
        chk("st.rdat", 32'(rsp_dat), 32'h5A5A);
        req_rd[0] = 1'b0;
        tick();
        chk("st.idle", 32'(busy), 32'h0);

        // reset pulse while STROBE waits on stb_o
        m_stb_en    = 1'b0;
        req_wr[1]   = 1'b1;
        req_addr[1] = 32'h30;
        req_dat[1]  = 16'h7777;
        tick();
        chk("rs.E.gnt", 32'(gnt), 32'h2);
        tick();
        chk_bus("rs.E1", 1'b1, 1'b1, 1'b0, 32'h30, 16'h7777);
        tick();
        chk("rs.hold.stb", 32'(mem.stb_i), 32'h1);
        rst = 1'b1;
        tick();
        chk_bus("rs.after", 1'b1, 1'b0, 1'b1, 32'h0, 16'h0);
        chk("rs.after.gnt",  32'(gnt),     32'h0);
        chk("rs.after.busy", 32'(busy),    32'h0);
        chk("rs.after.ack",  32'(rsp_ack), 32'h0);
        rst      = 1'b0;
        m_stb_en = 1'b1;
        tick();
        chk("rs.re.gnt", 32'(gnt),     32'h2);
        chk("rs.re.ack", 32'(rsp_ack), 32'h0);
        tick();
        chk_bus("rs.re.E1", 1'b1, 1'b1, 1'b0, 32'h30, 16'h7777);
        tick();
        chk("rs.re.ack2", 32'(rsp_ack), 32'h2);
        req_wr[1] = 1'b0;
        tick();
        chk("rs.idle", 32'(busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/mem_bus_arb.md
# mem_bus_arb

Shared-memory arbiter that lets up to four masters (the fxcpu16 core, a DMA engine, a debug loader) use one `mem_wif_t` memory port. Each master sees a simple request/acknowledge port. The arbiter selects one pending request, runs the full bus-grant / strobe / completion sequence on `mem`, returns read data with a one-cycle acknowledge pulse, and then re-arbitrates. It sits between the masters and the memory-side `mem_wif_t` slave.

## Interface
Parameters:
- NREQ, 2: number of requester ports; legal range 2..4.
- AW, 32: address width.
- DW, 16: data width.

Ports:
- mem.clk_i  input  1  clock, taken from the interface; all logic on its rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- mem  mem_wif_t.dev  -  downstream bus; the arbiter drives sel_i, addr_i, dat_o, we_i, stb_i and samples ack_o, cyc_o, stb_o, dat_i.
- req_rd_i  input  NREQ  per-port read request; level, held until that port's ack.
- req_wr_i  input  NREQ  per-port write request; level, held until that port's ack.
- req_addr_i  input  NREQ×AW  per-port address; stable while the request is held.
- req_dat_i  input  NREQ×DW  per-port write data.
- rsp_dat_o  output  DW  read data; valid in the ack cycle, held until the next read completes.
- rsp_ack_o  output  NREQ  one-cycle completion pulse to the served port.
- gnt_o  output  NREQ  one-hot owner of the current transaction; 0 when idle.
- busy_o  output  1  high in any state other than IDLE.

## Operation
- **Reset values:**
  - mem.sel_i=1, mem.we_i=1, mem.stb_i=0, mem.addr_i=0, mem.dat_o=0.
  - rsp_ack_o=0, rsp_dat_o=0, gnt_o=0, busy_o=0.
  - Round-robin pointer=0; state=IDLE.
- **IDLE:** a port is pending when req_rd_i or req_wr_i is high on it.
  - If any port is pending, select the winner (see Configuration).
  - Latch the winner's address, data and direction; set gnt_o; go to GRANT.
  - If both rd and wr are high on one port, treat it as a read.
- **GRANT:** while mem.cyc_o=1, hold everything.
  - If mem.cyc_o=0 and mem.ack_o=0: drive sel_i=0 to request the bus.
  - If mem.cyc_o=0 and mem.ack_o=1: sel_i=1, addr_i=latched address, stb_i=1.
    - Write: we_i=0 (active-low), dat_o=latched data.
  - Then go to STROBE.
- **STROBE:** wait for mem.stb_o=1. On it: stb_i=0, we_i=1, dat_o=0.
  - Write: pulse rsp_ack_o[winner], addr_i=0, go to DONE.
  - Read: go to RD_TAIL.
- **RD_TAIL:** wait for mem.cyc_o=0. Then capture mem.dat_i into rsp_dat_o, addr_i=0, pulse rsp_ack_o[winner], go to DONE.
- **DONE:** exactly one cycle. Clear gnt_o, advance the priority pointer, go to IDLE.
  - This cycle exists so the served master can drop its request before the next sample, which prevents a double grant.
- Requests on non-granted ports are never dropped; they wait.
- Request or address changes on the granted port after IDLE are ignored.
- **Reset mid-transaction:** outputs return to reset values at the next edge, the transaction is abandoned, no ack is issued, and stb_i falls immediately.

## Timing
- Let E be the edge at which IDLE samples a pending request. Assume ack_o=1, cyc_o=0, and stb_o returned one cycle after stb_i.
  - stb_i is high after E+1.
  - Write: rsp_ack_o is high for the cycle after E+2.
  - Read: rsp_ack_o is high for the cycle after E+3, with rsp_dat_o valid in that same cycle.
- DONE occupies the next cycle. The earliest next arbitration is at E+4 (write) or E+5 (read).
- Masters must deassert their request at the edge following their ack cycle at the latest.
- Each wait state (GRANT, STROBE, RD_TAIL) can stall without bound; there is no timeout.
- rsp_ack_o is never multi-hot and never lasts more than one cycle.

## Configuration
- MEM_BUS_ARB_RR_EN defined: round-robin.
  - After serving port k, search starts at (k+1) mod NREQ.
  - Any continuously pending port is served within NREQ transactions.
- Not defined: fixed priority; lowest port index wins. The pointer logic is omitted and port NREQ-1 can starve.

## Test plan
- Single read, port 0, addr 0x0000_0010, memory holds 0xBEEF:
  - sel_i stays 1 because ack_o is already high.
  - stb_i rises after E+1.
  - rsp_ack_o[0] pulses after E+3 with rsp_dat_o=0xBEEF.
- Single write, port 1, addr 0x20, data 0x1234:
  - mem sees addr_i=0x20, dat_o=0x1234, we_i=0 together with stb_i=1.
  - rsp_ack_o[1] pulses after E+2.
  - we_i=1, dat_o=0 afterwards.
- Ports 0 and 1 both continuously reading:
  - Defined: grants alternate 0,1,0,1.
  - Undefined: port 0 is granted every time.
- ack_o held low for 5 cycles in GRANT, then raised:
  - sel_i=0 for those cycles.
  - stb_i rises only after ack_o=1 with cyc_o=0.
  - No rsp_ack_o pulse occurs early.
- rst_i pulsed for 1 cycle while in STROBE:
  - Next cycle shows stb_i=0, sel_i=1, we_i=1, gnt_o=0, busy_o=0.
  - No rsp_ack_o pulse.
  - The held request is re-served from IDLE afterwards.
